// File: rtl/ram_io_responder.sv
// ram_io_responder: memory-side responder for the byte-serial RAM port.
// Serves RAM loads and stores with a registered one-cycle read latency.
// Decodes an IO window at addr[17:16]==2'b11, which holds:
//   - a TX output FIFO (DATA at 0x30000)
//   - a HALT/STATUS register (0x30004)
// Optional feature macro: RAM_INIT_EN (RAM starts zeroed at time 0).
module ram_io_responder #(
  parameter int unsigned ADDR_WIDTH     = 17,
  parameter int unsigned IO_FIFO_DEPTH  = 8,
  parameter int unsigned IO_FULL_MARGIN = 2,
  parameter              INIT_FILE      = "test.data"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ram_enable,
  input  logic        lw_type,
  input  logic [31:0] addr,
  input  logic [7:0]  byte_out,
  output logic [7:0]  byte_in,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        io_overflow,
  output logic        sim_halt
);

  localparam int unsigned PTR_W = $clog2(IO_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LP_DEPTH    = CNT_W'(IO_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LP_FULL_THR = CNT_W'(IO_FIFO_DEPTH - IO_FULL_MARGIN);
  localparam logic [17:0]      LP_IO_DATA  = 18'h30000;
  localparam logic [17:0]      LP_IO_HALT  = 18'h30004;
  localparam int unsigned      LP_UNUSED_INIT_BITS = $bits(INIT_FILE);

  logic [7:0]       r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [7:0]       r_fifo [0:IO_FIFO_DEPTH-1];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_byte_in;
  logic             r_io_full;
  logic             r_io_overflow;
  logic             r_sim_halt;

  logic                  w_accept;
  logic                  w_is_io;
  logic                  w_at_data;
  logic                  w_at_halt;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_store_ram;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_halt_wr;
  logic [CNT_W-1:0]      w_next_count;
  logic [7:0]            w_rd_data;
  logic                  w_unused;

  assign w_accept    = rst && rdy && ram_enable;
  assign w_is_io     = (addr[17:16] == 2'b11);
  assign w_at_data   = (addr[17:0] == LP_IO_DATA);
  assign w_at_halt   = (addr[17:0] == LP_IO_HALT);
  assign w_idx       = addr[ADDR_WIDTH-1:0];
  assign w_store_ram = w_accept && !lw_type && !w_is_io;
  assign w_push_req  = w_accept && !lw_type && w_at_data;
  assign w_halt_wr   = w_accept && !lw_type && w_at_halt;
  assign w_pop       = (r_count != '0) && tx_ready;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign w_push      = w_push_req && ((r_count != LP_DEPTH) || w_pop);
  assign w_next_count = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_unused    = ^addr[31:18];

  assign byte_in        = r_byte_in;
  assign io_buffer_full = r_io_full;
  assign tx_data        = r_fifo[r_rd_ptr];
  assign tx_valid       = (r_count != '0);
  assign io_overflow    = r_io_overflow;
  assign sim_halt       = r_sim_halt;

`ifdef RAM_INIT_EN
  initial begin
    for (int unsigned i = 0; i < (1 << ADDR_WIDTH); i++) r_mem[i] = '0;
  end
`endif

  // Read mux: RAM byte, FIFO occupancy at STATUS, zero elsewhere in IO.
  always_comb begin
    w_rd_data = '0;
    if (!w_is_io) w_rd_data = r_mem[w_idx];
    else if (w_at_halt) w_rd_data = 8'(r_count);
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_store_ram) r_mem[w_idx] <= byte_out;
  end

  // Registered load data; held on stores, idle cycles and rdy==0.
  always_ff @(posedge clk) begin
    if (!rst) r_byte_in <= '0;
    else if (w_accept && lw_type) r_byte_in <= w_rd_data;
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= byte_out;
  end

  // FIFO pointers, occupancy, back-pressure and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_io_full     <= 1'b0;
      r_io_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count   <= w_next_count;
      r_io_full <= (w_next_count >= LP_FULL_THR);
      if (w_push_req && !w_push) r_io_overflow <= 1'b1;
    end
  end

  // HALT pulse; frozen along with the rest of the request side when rdy==0.
  always_ff @(posedge clk) begin
    if (!rst) r_sim_halt <= 1'b0;
    else if (rdy) r_sim_halt <= w_halt_wr;
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Testbench for ram_io_responder: queue/associative-array reference model
// compared on every negedge, plus directed vectors with literal expectations.
module tb_ram_io_responder;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic        clk = 1'b0;
  logic        rst, rdy, ram_enable, lw_type, tx_ready;
  logic [31:0] addr;
  logic [7:0]  byte_out;
  logic [7:0]  byte_in, tx_data;
  logic        io_buffer_full, tx_valid, io_overflow, sim_halt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Reference model state
  logic [7:0] m_mem [int];
  logic [7:0] m_q [$];
  logic [7:0] m_byte_in;
  bit         m_bin_known;
  bit         m_ovf, m_halt, m_full;

  ram_io_responder #(.ADDR_WIDTH(17), .IO_FIFO_DEPTH(DEPTH), .IO_FULL_MARGIN(MARGIN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ram_enable(ram_enable), .lw_type(lw_type),
    .addr(addr), .byte_out(byte_out), .byte_in(byte_in), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .io_overflow(io_overflow), .sim_halt(sim_halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one request per edge, applied in the order the rules describe.
  always @(posedge clk) begin
    int   sz;
    bit   acc, io;
    int   off, idx;
    if (!rst) begin
      m_byte_in = 8'h00; m_bin_known = 1; m_q.delete();
      m_ovf = 0; m_halt = 0; m_full = 0;
    end else begin
      sz  = m_q.size();
      acc = rdy && ram_enable;
      io  = (addr[17:16] == 2'b11);
      off = int'(addr & 32'h3FFFF);
      idx = int'(addr & 32'h1FFFF);
      if (acc && lw_type) begin
        if (io) begin
          m_byte_in = (off == 32'h30004) ? 8'(sz) : 8'h00;
          m_bin_known = 1;
        end else if (m_mem.exists(idx)) begin
          m_byte_in = m_mem[idx];
          m_bin_known = 1;
        end else m_bin_known = 0;
      end
      if (acc && !lw_type && !io) m_mem[idx] = byte_out;
      if (sz > 0 && tx_ready) void'(m_q.pop_front());
      if (acc && !lw_type && off == 32'h30000) begin
        if (m_q.size() < DEPTH) m_q.push_back(byte_out);
        else m_ovf = 1;
      end
      m_full = (m_q.size() >= DEPTH - MARGIN);
      if (rdy) m_halt = acc && !lw_type && off == 32'h30004;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_bin_known) chk("byte_in", byte_in, m_byte_in);
      chk("io_buffer_full", io_buffer_full, m_full);
      chk("tx_valid", tx_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
      chk("io_overflow", io_overflow, m_ovf);
      chk("sim_halt", sim_halt, m_halt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic en, input logic lw, input logic [31:0] a, input logic [7:0] d);
    ram_enable = en; lw_type = lw; addr = a; byte_out = d;
  endtask

  logic [31:0] addr_tbl [10];

  initial begin
    rst = 0; rdy = 1; tx_ready = 0;
    req(0, 0, 0, 0);
    tick();
    chk_en = 1;
    tick();
    rst = 1;
    chk("rst byte_in", byte_in, 8'h00);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst overflow", io_overflow, 1'b0);
    chk("rst full", io_buffer_full, 1'b0);
    chk("rst halt", sim_halt, 1'b0);

    // Store then load same address
    req(1, 0, 32'h10, 8'hA5); tick();
    req(1, 1, 32'h10, 8'h00); tick();
    chk("t1 load", byte_in, 8'hA5);

    // Back-to-back streaming loads
    for (int i = 0; i < 4; i++) begin
      req(1, 0, 32'h100 + i, 8'h11 * (i + 1)); tick();
    end
    chk("stores keep byte_in", byte_in, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      req(1, 1, 32'h100 + i, 8'h00); tick();
      chk("stream", byte_in, 8'h11 * (i + 1));
    end
    // Load then store same address: load sees old byte
    req(1, 1, 32'h100, 8'h00); tick();
    req(1, 0, 32'h100, 8'h99); tick();
    chk("load before store", byte_in, 8'h11);
    req(1, 1, 32'h100, 8'h00); tick();
    chk("load after store", byte_in, 8'h99);

    // HALT pulse, then rdy==0 freeze
    req(1, 0, 32'h30004, 8'h00); tick();
    chk("halt pulse", sim_halt, 1'b1);
    req(0, 0, 0, 0); tick();
    chk("halt clears", sim_halt, 1'b0);
    req(1, 0, 32'h20, 8'h5A); tick();
    rdy = 0; req(1, 1, 32'h20, 8'h00); tick();
    chk("rdy0 hold", byte_in, 8'h99);
    rdy = 1; tick();
    chk("rdy1 load", byte_in, 8'h5A);

    // Back-pressure threshold and in-order drain
    tx_ready = 0;
    for (int i = 0; i < 6; i++) begin
      req(1, 0, 32'h30000, 8'(i + 1)); tick();
      if (i == 4) chk("full at 5", io_buffer_full, 1'b0);
      if (i == 5) chk("full at 6", io_buffer_full, 1'b1);
    end
    req(0, 0, 0, 0); tx_ready = 1;
    for (int k = 0; k < 6; k++) begin
      chk("drain order", tx_data, 8'(k + 1));
      tick();
      if (k == 0) chk("full drops", io_buffer_full, 1'b0);
    end
    chk("drained", tx_valid, 1'b0);

    // Overflow, status read, unmapped IO, push+pop at full
    tx_ready = 0;
    for (int i = 0; i < 8; i++) begin
      req(1, 0, 32'h30000, 8'h10 + 8'(i)); tick();
    end
    req(1, 0, 32'h30000, 8'hEE); tick();
    chk("overflow set", io_overflow, 1'b1);
    chk("head kept", tx_data, 8'h10);
    req(1, 1, 32'h30004, 8'h00); tick();
    chk("status 8", byte_in, 8'h08);
    req(1, 1, 32'h30000, 8'h00); tick();
    chk("data reads 0", byte_in, 8'h00);
    req(1, 0, 32'h30008, 8'h55); tick();
    req(1, 1, 32'h30008, 8'h00); tick();
    chk("unmapped reads 0", byte_in, 8'h00);
    tx_ready = 1; req(1, 0, 32'h30000, 8'h77); tick();
    tx_ready = 0; req(1, 1, 32'h30004, 8'h00); tick();
    chk("push+pop at full", byte_in, 8'h08);
    req(0, 0, 0, 0); tx_ready = 1;
    for (int k = 0; k < 9; k++) tick();
    chk("overflow sticky", io_overflow, 1'b1);

    // Mixed random traffic against the model
    addr_tbl = '{32'h10, 32'h20, 32'h100, 32'h101, 32'h102, 32'h103,
                 32'hFFFC0010, 32'h30000, 32'h30004, 32'h30008};
    for (int n = 0; n < 300; n++) begin
      rdy      = ($urandom_range(0, 4) != 0);
      tx_ready = ($urandom_range(0, 2) == 0);
      req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          addr_tbl[$urandom_range(0, 9)], 8'($urandom));
      tick();
    end
    rdy = 1;

    // Reset mid-stream with FIFO occupied
    tx_ready = 0; req(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) tick();
    tx_ready = 1;
    for (int k = 0; k < 10; k++) tick();
    tx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      req(1, 0, 32'h30000, 8'hA1 + 8'(i)); tick();
    end
    req(1, 0, 32'h40, 8'h3C); tick();
    req(1, 1, 32'h40, 8'h00); tick();
    chk("pre-rst byte_in", byte_in, 8'h3C);
    chk("pre-rst tx_valid", tx_valid, 1'b1);
    chk("pre-rst overflow", io_overflow, 1'b1);
    rst = 0; req(1, 1, 32'h40, 8'h00); tick();
    chk("rst byte_in", byte_in, 8'h00);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst overflow", io_overflow, 1'b0);
    chk("rst full", io_buffer_full, 1'b0);
    rst = 1; req(0, 0, 0, 0); tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
